// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in core clock cycles.
// Latency: period_valid follows the synchronized edge by one cycle; no backpressure.
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clk_meas,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             timeout_q, timeout_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             meas_edge;

  // The synchronizer free-runs so a level already high at arming is not seen as an edge.
  assign meas_edge = s2_q & ~s3_q;

  always_comb begin
    s1_d      = clk_meas;
    s2_d      = s1_q;
    s3_d      = s2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    timeout_d = timeout_q;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARMED;
        end
        ARMED: begin
          if (meas_edge) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge on the saturation cycle still counts as a valid measurement.
          if (meas_edge) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARMED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      timeout_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      timeout_q <= timeout_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a default-width and a 4-bit instance, checked against
// an edge-timestamp model (period = spacing of rising edges, pulse 3 cycles after a rise).
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cm16 = 1'b0, en16 = 1'b0, cm4 = 1'b0, en4 = 1'b0;
  logic [15:0] per16;
  logic        pv16, to16, busy16;
  logic [3:0]  per4;
  logic        pv4, to4, busy4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int cap16_c[$], cap16_p[$];
  int cap4_c[$], cap4_p[$], cap4_t[$];
  int rises[$];
  int exp_c[$], exp_p[$];

  clk_period_meter dut (
    .clk(clk), .rst_b(rst_b), .clk_meas(cm16), .en(en16),
    .period(per16), .period_valid(pv16), .timeout(to16), .busy(busy16)
  );

  clk_period_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .clk_meas(cm4), .en(en4),
    .period(per4), .period_valid(pv4), .timeout(to4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pv16) begin
      cap16_c.push_back(cyc);
      cap16_p.push_back(int'(per16));
    end
    if (pv4) begin
      cap4_c.push_back(cyc);
      cap4_p.push_back(int'(per4));
      cap4_t.push_back(int'(to4));
    end
  end

  // Called on a negedge; leaves on a negedge. Records the cycle of each rise.
  task automatic period16(input int hi, input int lo);
    cm16 = 1'b1;
    rises.push_back(cyc);
    repeat (hi) @(negedge clk);
    cm16 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic period4(input int hi, input int lo);
    cm4 = 1'b1;
    rises.push_back(cyc);
    repeat (hi) @(negedge clk);
    cm4 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Every rise after the first reports the gap to the previous rise; a gap the
  // counter cannot hold is a timeout and that rise just restarts the chain.
  task automatic build_model(input int maxp);
    exp_c.delete();
    exp_p.delete();
    for (int i = 1; i < rises.size(); i++) begin
      if (rises[i] - rises[i-1] <= maxp) begin
        exp_c.push_back(rises[i] + 3);
        exp_p.push_back(rises[i] - rises[i-1]);
      end
    end
  endtask

  task automatic rearm16();
    @(negedge clk);
    en16 = 1'b0;
    @(negedge clk);
    en16 = 1'b1;
    repeat (3) @(negedge clk);
    rises.delete();
    cap16_c.delete();
    cap16_p.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (per16 !== 16'd0) begin errors++; $display("FAIL reset_period16 got %0d exp 0", per16); end
    checks++; if (pv16 !== 1'b0) begin errors++; $display("FAIL reset_pv16 got %b exp 0", pv16); end
    checks++; if (to16 !== 1'b0) begin errors++; $display("FAIL reset_timeout16 got %b exp 0", to16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16 got %b exp 0", busy16); end
    checks++; if (per4 !== 4'd0) begin errors++; $display("FAIL reset_period4 got %0d exp 0", per4); end
    checks++; if (pv4 !== 1'b0) begin errors++; $display("FAIL reset_pv4 got %b exp 0", pv4); end
    checks++; if (to4 !== 1'b0) begin errors++; $display("FAIL reset_timeout4 got %b exp 0", to4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b exp 0", busy4); end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL idle_busy16 got %b exp 0", busy16); end
  endtask

  task automatic test_basic();
    cm16 = 1'b1;
    repeat (3) @(negedge clk);
    en16 = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy16); end
    cm16 = 1'b0;
    repeat (3) @(negedge clk);
    rises.delete();
    cap16_c.delete();
    cap16_p.delete();
    repeat (5) period16(5, 5);
    repeat (6) @(negedge clk);
    build_model(65535);
    checks++; if (cap16_c.size() != exp_c.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", cap16_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < cap16_c.size(); i++) begin
      checks++;
      if (cap16_c[i] !== exp_c[i] || cap16_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL basic_pulse%0d got cyc %0d per %0d exp cyc %0d per %0d", i, cap16_c[i], cap16_p[i], exp_c[i], exp_p[i]);
      end
    end
    checks++; if (per16 !== 16'd10) begin errors++; $display("FAIL basic_period got %0d exp 10", per16); end
  endtask

  task automatic test_period_change();
    rearm16();
    repeat (4) period16(5, 5);
    period16(5, 9);
    repeat (4) period16(7, 7);
    repeat (6) @(negedge clk);
    build_model(65535);
    checks++; if (cap16_c.size() != exp_c.size()) begin errors++; $display("FAIL change_count got %0d exp %0d", cap16_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < cap16_c.size(); i++) begin
      checks++;
      if (cap16_c[i] !== exp_c[i] || cap16_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL change_pulse%0d got cyc %0d per %0d exp cyc %0d per %0d", i, cap16_c[i], cap16_p[i], exp_c[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_random();
    rearm16();
    for (int n = 0; n < 25; n++) period16(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
    repeat (6) @(negedge clk);
    build_model(65535);
    checks++; if (cap16_c.size() != exp_c.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", cap16_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < cap16_c.size(); i++) begin
      checks++;
      if (cap16_c[i] !== exp_c[i] || cap16_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL random_pulse%0d got cyc %0d per %0d exp cyc %0d per %0d", i, cap16_c[i], cap16_p[i], exp_c[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_en_drop();
    int old_per;
    old_per = exp_p[exp_p.size()-1];
    cap16_c.delete();
    cap16_p.delete();
    cm16 = 1'b1;
    repeat (2) @(negedge clk);
    en16 = 1'b0;
    @(negedge clk);
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b exp 0", busy16); end
    checks++; if (int'(per16) !== old_per) begin errors++; $display("FAIL endrop_period got %0d exp %0d", per16, old_per); end
    checks++; if (pv16 !== 1'b0) begin errors++; $display("FAIL endrop_pv got %b exp 0", pv16); end
    cm16 = 1'b0;
    en16 = 1'b1;
    @(negedge clk);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL endrop_rearm_busy got %b exp 1", busy16); end
    repeat (3) @(negedge clk);
    checks++; if (cap16_c.size() != 0) begin errors++; $display("FAIL endrop_no_pulse got %0d exp 0", cap16_c.size()); end
    rises.delete();
    repeat (3) period16(4, 4);
    repeat (6) @(negedge clk);
    build_model(65535);
    checks++; if (cap16_c.size() != exp_c.size()) begin errors++; $display("FAIL endrop_count got %0d exp %0d", cap16_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < cap16_c.size(); i++) begin
      checks++;
      if (cap16_c[i] !== exp_c[i] || cap16_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL endrop_pulse%0d got cyc %0d per %0d exp cyc %0d per %0d", i, cap16_c[i], cap16_p[i], exp_c[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int r;
    en4 = 1'b1;
    repeat (3) @(negedge clk);
    cap4_c.delete();
    cap4_p.delete();
    cap4_t.delete();
    cm4 = 1'b1;
    r = cyc;
    repeat (2) @(negedge clk);
    cm4 = 1'b0;
    repeat (r + 17 - cyc) @(negedge clk);
    checks++; if (to4 !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", to4); end
    @(negedge clk);
    checks++; if (to4 !== 1'b1) begin errors++; $display("FAIL timeout_set got %b exp 1", to4); end
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL timeout_busy got %b exp 1", busy4); end
    checks++; if (per4 !== 4'd0) begin errors++; $display("FAIL timeout_period got %0d exp 0", per4); end
    repeat (4) @(negedge clk);
    checks++; if (to4 !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", to4); end
    checks++; if (cap4_c.size() != 0) begin errors++; $display("FAIL timeout_no_pulse got %0d exp 0", cap4_c.size()); end
  endtask

  task automatic test_edge_at_max();
    en4 = 1'b0;
    @(negedge clk);
    checks++; if (to4 !== 1'b0) begin errors++; $display("FAIL max_timeout_cleared got %b exp 0", to4); end
    en4 = 1'b1;
    repeat (3) @(negedge clk);
    rises.delete();
    cap4_c.delete();
    cap4_p.delete();
    cap4_t.delete();
    period4(5, 10);
    period4(5, 11);
    period4(2, 6);
    repeat (6) @(negedge clk);
    build_model(15);
    checks++; if (cap4_c.size() != exp_c.size()) begin errors++; $display("FAIL max_count got %0d exp %0d", cap4_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < cap4_c.size(); i++) begin
      checks++;
      if (cap4_c[i] !== exp_c[i] || cap4_p[i] !== exp_p[i] || cap4_t[i] !== 0) begin
        errors++;
        $display("FAIL max_pulse%0d got cyc %0d per %0d to %0d exp cyc %0d per %0d to 0", i, cap4_c[i], cap4_p[i], cap4_t[i], exp_c[i], exp_p[i]);
      end
    end
    checks++; if (per4 !== 4'd15) begin errors++; $display("FAIL max_period got %0d exp 15", per4); end
    checks++; if (to4 !== 1'b1) begin errors++; $display("FAIL max_gap16_timeout got %b exp 1", to4); end
  endtask

  task automatic test_reset_mid();
    rearm16();
    repeat (3) period16(5, 5);
    repeat (5) @(negedge clk);
    checks++; if (per16 !== 16'd10) begin errors++; $display("FAIL rstmid_pre_period got %0d exp 10", per16); end
    cap16_c.delete();
    cap16_p.delete();
    cm16 = 1'b1;
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checks++; if (per16 !== 16'd0) begin errors++; $display("FAIL rstmid_period got %0d exp 0", per16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy16); end
    checks++; if (pv16 !== 1'b0 || to16 !== 1'b0) begin errors++; $display("FAIL rstmid_flags got pv %b to %b exp 0 0", pv16, to16); end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rstmid_release_busy got %b exp 0", busy16); end
    @(negedge clk);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL rstmid_first_edge_busy got %b exp 1", busy16); end
    repeat (6) @(negedge clk);
    checks++; if (cap16_c.size() != 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", cap16_c.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period_change();
    test_random();
    test_en_drop();
    test_timeout();
    test_edge_at_max();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
